// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register sequencer: register CTRL
// codes, command opcodes, FSM states and small decode helpers.
package shreg_pkg;

  localparam int REG_W  = 8;
  localparam int BITS_W = 4;

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_SHL  = 2'b01,
    CTRL_LOAD = 2'b10,
    CTRL_SHR  = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    OP_TX   = 2'b00,
    OP_RX   = 2'b01,
    OP_XFER = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // A length field of zero stands for a full 8-bit transfer.
  function automatic logic [BITS_W-1:0] len_to_bits(input logic [2:0] len);
    return (len == 3'd0) ? 4'd8 : {1'b0, len};
  endfunction

  function automatic ctrl_e shift_code(input logic dir);
    return dir ? CTRL_SHR : CTRL_SHL;
  endfunction

endpackage

// File: rtl/shreg_bit_timer.sv
// Bit-period down-counter: loads CLK_DIV-1 on start, ticks when it reaches
// zero and reloads, until cleared.
module shreg_bit_timer #(
  parameter int CLK_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count_q, count_d;
  logic             run_q, run_d;

  always_comb begin
    count_d = count_q;
    run_d   = run_q;
    if (clear) begin
      count_d = '0;
      run_d   = 1'b0;
    end else if (start) begin
      count_d = RELOAD;
      run_d   = 1'b1;
    end else if (run_q) begin
      count_d = (count_q == '0) ? RELOAD : count_q - DIV_W'(1);
    end
  end

  assign tick = run_q && (count_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Command sequencer for the 8-bit universal shift register: runs TX, RX and
// XFER transfers of 1..8 bits at one shift per CLK_DIV clock cycles.
module shreg_seq_ctrl
  import shreg_pkg::*;
#(
  parameter int   CLK_DIV = 4,
  parameter int   DIV_W   = 8,
  parameter logic FILL    = 1'b0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_dir,
  input  logic [2:0]       cmd_len,
  input  logic [REG_W-1:0] cmd_data,
  input  logic             abort,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [1:0]       reg_ctrl,
  output logic             reg_enable,
  output logic             reg_s_in,
  output logic [REG_W-1:0] reg_d,
  input  logic [REG_W-1:0] reg_q,
  output logic             done_valid,
  output logic [REG_W-1:0] done_data,
  output logic             done_err
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                dir_q, dir_d;
  logic [BITS_W-1:0]   bits_left_q, bits_left_d;
  ctrl_e               reg_ctrl_q, reg_ctrl_d;
  logic                reg_enable_q, reg_enable_d;
  logic [REG_W-1:0]    reg_d_q, reg_d_d;
  logic                done_valid_q, done_valid_d;
  logic                done_err_q, done_err_d;

  logic accept;
  logic busy_q;
  logic tick;
  logic timer_start;
  logic timer_clear;

  assign cmd_ready = (state_q == ST_IDLE) && !RESET;
  assign accept    = cmd_valid && cmd_ready;
  assign busy_q    = (state_q == ST_LOAD) || (state_q == ST_SHIFT);

  // The timer starts on the accept edge so that its ticks precede each
  // registered shift enable by exactly one cycle.
  assign timer_start = accept && (cmd_op != OP_RSVD);
  assign timer_clear = (state_d != ST_LOAD) && (state_d != ST_SHIFT);

  shreg_bit_timer #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_bit_timer (
    .clk   (CLOCK),
    .rst   (RESET),
    .start (timer_start),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dir_d        = dir_q;
    bits_left_d  = bits_left_q;
    reg_ctrl_d   = CTRL_HOLD;
    reg_enable_d = 1'b0;
    reg_d_d      = reg_d_q;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d        = op_e'(cmd_op);
          dir_d       = cmd_dir;
          bits_left_d = len_to_bits(cmd_len);
          if (cmd_op == OP_RSVD) begin
            state_d      = ST_DONE;
            done_valid_d = 1'b1;
            done_err_d   = 1'b1;
          end else begin
            state_d      = ST_LOAD;
            reg_ctrl_d   = CTRL_LOAD;
            reg_enable_d = 1'b1;
            reg_d_d      = (cmd_op == OP_RX) ? '0 : cmd_data;
          end
        end
      end
      ST_LOAD, ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_SHIFT) && reg_enable_q && (bits_left_q == '0)) begin
          // The last shift is on the register's input this cycle.
          state_d      = ST_DONE;
          done_valid_d = 1'b1;
        end else begin
          state_d    = ST_SHIFT;
          reg_ctrl_d = shift_code(dir_q);
          if (tick && (bits_left_q != '0)) begin
            reg_enable_d = 1'b1;
            bits_left_d  = bits_left_q - BITS_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_TX;
      dir_q        <= 1'b0;
      bits_left_q  <= '0;
      reg_ctrl_q   <= CTRL_HOLD;
      reg_enable_q <= 1'b0;
      reg_d_q      <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      dir_q        <= dir_d;
      bits_left_q  <= bits_left_d;
      reg_ctrl_q   <= reg_ctrl_d;
      reg_enable_q <= reg_enable_d;
      reg_d_q      <= reg_d_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end

  assign reg_ctrl   = reg_ctrl_q;
  assign reg_enable = reg_enable_q;
  assign reg_d      = reg_d_q;
  assign reg_s_in   = busy_q ? ((op_q == OP_TX) ? FILL : ser_in) : 1'b0;
  assign ser_out    = (state_q == ST_SHIFT) ? (dir_q ? reg_q[0] : reg_q[REG_W-1]) : 1'b0;
  assign done_valid = done_valid_q;
  // Register Q is stable during the DONE cycle and already holds the last shift.
  assign done_data  = done_valid_q ? reg_q : '0;
  assign done_err   = done_err_q;

endmodule
